// File: rtl/frame_streamer.sv
// ----------------------------------------------------------------------------
// frame_streamer
//
// Purpose:
//   Upstream feeder for the CNN inference chip. One IMG_W x IMG_H image of
//   DATA_BITS-wide pixels is collected from the host over a valid/ready byte
//   interface into an internal frame RAM. While the frame is being collected
//   the chip core is held in reset. Once the frame is complete, the core is
//   released and the pixels are streamed to it row-major, one per cycle, with
//   no bubbles. The core's 4-bit decision is then captured and reported, and
//   the streamer returns to loading the next frame. If the core never answers
//   within TIMEOUT cycles the frame is abandoned.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      host pixel valid
//   in_data       host pixel, row-major order
//   in_ready      streamer can accept a pixel (high only while loading)
//   core_rst_n    registered active-low reset to the chip core
//   pix_out       registered pixel to the chip data_in
//   dec_valid_in  chip decision valid, single-cycle pulse
//   dec_in        chip decision digit
//   result        last captured decision
//   result_valid  one-cycle pulse when result updates
//   timeout       one-cycle pulse when a frame is abandoned
//   busy          high while priming, streaming or waiting for a decision
// ----------------------------------------------------------------------------
module frame_streamer #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int TIMEOUT   = 4095
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 core_rst_n,
  output logic [DATA_BITS-1:0] pix_out,
  input  logic                 dec_valid_in,
  input  logic [3:0]           dec_in,
  output logic [3:0]           result,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam int N   = IMG_W * IMG_H;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_BITS-1:0] LAST_WR   = ADDR_BITS'(N - 1);
  localparam logic [ADDR_BITS:0]   END_RD    = (ADDR_BITS + 1)'(N);
  localparam logic [WCW-1:0]       WAIT_TERM = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_PRIME,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  // One bit wider than the RAM address so that "all N pixels issued" is
  // representable even when N fills the whole address space.
  logic [ADDR_BITS:0]     rd_addr_q, rd_addr_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic [DATA_BITS-1:0]   pix_out_q;
  logic [3:0]             result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   timeout_q, timeout_d;
  logic                   mem_we;

  logic [DATA_BITS-1:0]   mem [N];

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_LOAD;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wait_cnt_q     <= '0;
      core_rst_n_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      wait_cnt_q     <= wait_cnt_d;
      core_rst_n_q   <= core_rst_n_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next-state logic. The read address runs one ahead of the pixel on
  // pix_out: PRIME reads address 0, and STREAM cycle k reads address k+1,
  // so the last STREAM cycle is the one where rd_addr_q has reached N.
  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    rd_addr_d      = rd_addr_q;
    wait_cnt_d     = '0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      S_LOAD: begin
        rd_addr_d = '0;
        if (in_valid) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_WR) begin
            wr_addr_d = '0;
            state_d   = S_PRIME;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end

      S_PRIME: begin
        rd_addr_d = rd_addr_q + 1'b1;
        state_d   = S_STREAM;
      end

      S_STREAM: begin
        if (rd_addr_q == END_RD) begin
          rd_addr_d = '0;
          state_d   = S_WAIT;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end

      S_WAIT: begin
        // A decision arriving on the terminal cycle still wins over timeout.
        if (dec_valid_in) begin
          result_d       = dec_in;
          result_valid_d = 1'b1;
          state_d        = S_LOAD;
        end else if (wait_cnt_q == WAIT_TERM) begin
          timeout_d = 1'b1;
          state_d   = S_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    // The core runs exactly while the streamer streams or waits.
    core_rst_n_d = (state_d == S_STREAM) || (state_d == S_WAIT);
  end

  // Frame RAM write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= in_data;
    end
  end

  // Frame RAM synchronous read port; its output register is pix_out, which
  // is forced to zero whenever the next cycle is not a STREAM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out_q <= '0;
    end else if (state_d == S_STREAM) begin
      pix_out_q <= mem[rd_addr_q[ADDR_BITS-1:0]];
    end else begin
      pix_out_q <= '0;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q != S_LOAD);
  assign core_rst_n   = core_rst_n_q;
  assign pix_out      = pix_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_frame_streamer.sv
// ----------------------------------------------------------------------------
// tb_frame_streamer
//
// Purpose:
//   Self-checking bench for frame_streamer. A behavioural model tracks the
//   frame contents and how many cycles have elapsed since the frame became
//   complete, and from that alone derives every output each cycle. Directed
//   frames pin the model with hand-computed values; random frames follow.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_frame_streamer;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 10;
  localparam int TIMEOUT   = 15;
  localparam int N         = IMG_W * IMG_H;

  logic                 clk          = 1'b0;
  logic                 rst_n        = 1'b0;
  logic                 in_valid     = 1'b0;
  logic [DATA_BITS-1:0] in_data      = '0;
  logic                 dec_valid_in = 1'b0;
  logic [3:0]           dec_in       = '0;
  logic                 in_ready;
  logic                 core_rst_n;
  logic [DATA_BITS-1:0] pix_out;
  logic [3:0]           result;
  logic                 result_valid;
  logic                 timeout;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  frame_streamer #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .core_rst_n  (core_rst_n),
    .pix_out     (pix_out),
    .dec_valid_in(dec_valid_in),
    .dec_in      (dec_in),
    .result      (result),
    .result_valid(result_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point shared by the per-cycle compare and the
  // directed literal expectations.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Drive all inputs for the next cycle, starting at the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic dv, input logic [3:0] di);
    @(negedge clk);
    in_valid     = v;
    in_data      = d;
    dec_valid_in = dv;
    dec_in       = di;
  endtask

  // Behavioural model. mAge < 0 means the frame is still being collected;
  // otherwise it counts cycles since the frame completed: age 0 is the
  // priming cycle, ages 1..N carry pixels 0..N-1, ages above N are spent
  // waiting for the decision, at most TIMEOUT of them.
  logic [7:0] mFrame [N];
  int         mAge    = -1;
  int         mLoaded = 0;
  logic [3:0] mResult = '0;
  logic       mRv     = 1'b0;
  logic       mTo     = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mAge    = -1;
      mLoaded = 0;
      mResult = '0;
      mRv     = 1'b0;
      mTo     = 1'b0;
    end else begin
      mRv = 1'b0;
      mTo = 1'b0;
      if (mAge < 0) begin
        if (in_valid) begin
          mFrame[mLoaded] = in_data;
          mLoaded++;
          if (mLoaded == N) begin
            mLoaded = 0;
            mAge    = 0;
          end
        end
      end else if (mAge <= N) begin
        mAge++;
      end else if (dec_valid_in) begin
        mResult = dec_in;
        mRv     = 1'b1;
        mAge    = -1;
      end else if (mAge - N == TIMEOUT) begin
        mTo  = 1'b1;
        mAge = -1;
      end else begin
        mAge++;
      end
    end
  end

  // Per-cycle comparison, sampled well after the rising edge.
  always @(posedge clk) begin
    logic [7:0] expPix;
    #2;
    expPix = (mAge >= 1 && mAge <= N) ? mFrame[mAge-1] : 8'd0;
    checkOutput("in_ready", in_ready, mAge < 0);
    checkOutput("busy", busy, mAge >= 0);
    checkOutput("core_rst_n", core_rst_n, mAge >= 1);
    checkOutput("pix_out", pix_out, expPix);
    checkOutput("result", result, mResult);
    checkOutput("result_valid", result_valid, mRv);
    checkOutput("timeout", timeout, mTo);
  end

  // Present `count` bytes to the host port. Mode 0: k mod 256, valid held.
  // Mode 1: same data, valid toggling, junk on idle cycles. Mode 2: random
  // data and valid. Mode 3: constant 0xAA, valid held.
  task automatic loadFrame(input int mode, input int count);
    int         accepted = 0;
    int         budget   = 0;
    logic       v;
    logic [7:0] d;
    while (accepted < count && budget < 4 * N) begin
      case (mode)
        0:       begin v = 1'b1;                d = 8'(accepted); end
        1:       begin v = (budget % 2 == 0);   d = v ? 8'(accepted) : 8'($urandom); end
        2:       begin v = 1'($urandom_range(0, 1)); d = 8'($urandom); end
        default: begin v = 1'b1;                d = 8'hAA; end
      endcase
      applyStimulus(v, d, 1'b0, 4'd0);
      if (v && in_ready) accepted++;
      budget++;
    end
    checkOutput("load_accepts", accepted, count);
    if (mode == 0) checkOutput("load_cycles", budget, count);
  endtask

  // Advance until the core is released; returns cycles taken.
  task automatic waitCore(output int cyc);
    cyc = 0;
    while (!core_rst_n && cyc < 50) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
      cyc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
  endtask

  // Random core behaviour until the streamer is back in LOAD.
  task automatic randomPhase();
    int   cyc  = 0;
    logic done = 1'b0;
    while (!done && cyc < N + TIMEOUT + 40) begin
      @(negedge clk);
      done         = in_ready;
      in_valid     = done ? 1'b0 : 1'($urandom_range(0, 1));
      in_data      = 8'($urandom);
      dec_valid_in = done ? 1'b0 : ($urandom_range(0, 39) == 0);
      dec_in       = 4'($urandom);
      cyc++;
    end
    checkOutput("random_return", done, 1'b1);
  endtask

  initial begin
    int c;
    int aa;

    // Reset state.
    idle(3);
    checkOutput("rst_core", core_rst_n, 0);
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    rst_n = 1'b1;

    // Frame 1: k mod 256, valid held high.
    loadFrame(0, N);
    waitCore(c);
    checkOutput("core_rise_delay", c, 2);
    checkOutput("pix_k0", pix_out, 0);
    idle(300);
    checkOutput("pix_k300", pix_out, 44);
    idle(483);
    checkOutput("pix_k783", pix_out, 15);
    idle(1);
    checkOutput("wait_pix", pix_out, 0);
    checkOutput("wait_core", core_rst_n, 1);
    idle(2);
    applyStimulus(1'b0, 8'd0, 1'b1, 4'd7);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("dec7_result", result, 7);
    checkOutput("dec7_valid", result_valid, 1);
    checkOutput("dec7_core", core_rst_n, 0);
    checkOutput("dec7_ready", in_ready, 1);

    // Frame 2: back-to-back, toggling valid; a decision during STREAM is
    // ignored, a later WAIT decision is captured.
    loadFrame(1, N);
    waitCore(c);
    checkOutput("core_rise_delay2", c, 2);
    idle(100);
    applyStimulus(1'b0, 8'd0, 1'b1, 4'd3);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("ign_result", result, 7);
    checkOutput("ign_valid", result_valid, 0);
    checkOutput("ign_core", core_rst_n, 1);
    idle(N - 102);
    applyStimulus(1'b0, 8'd0, 1'b1, 4'd5);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("dec5_result", result, 5);
    checkOutput("dec5_valid", result_valid, 1);

    // Frame 3: random load, host junk during STREAM, no decision -> timeout.
    loadFrame(2, N);
    waitCore(c);
    repeat (N) applyStimulus(1'b1, 8'($urandom), 1'b0, 4'd0);
    checkOutput("wait0_busy", busy, 1);
    c = 0;
    while (!timeout && c < 40) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
      c++;
    end
    checkOutput("timeout_delay", c, TIMEOUT);
    checkOutput("to_result", result, 5);
    checkOutput("to_core", core_rst_n, 0);
    checkOutput("to_ready", in_ready, 1);

    // Frame 4: reset after 400 bytes, then a full 0xAA frame.
    loadFrame(2, 400);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_core", core_rst_n, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_pix", pix_out, 0);
    checkOutput("mid_rst_result", result, 0);
    idle(3);
    rst_n = 1'b1;
    loadFrame(3, N);
    waitCore(c);
    aa = 0;
    repeat (N) begin
      if (pix_out == 8'hAA) aa++;
      applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    end
    checkOutput("aa_count", aa, N);
    applyStimulus(1'b0, 8'd0, 1'b1, 4'd9);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("dec9_result", result, 9);

    // Random frames with random core behaviour.
    repeat (4) begin
      loadFrame(2, N);
      randomPhase();
    end

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
